// File: rtl/spi_slave_xcvr_if.sv
// Pin and core-side handshake bundle for spi_slave_xcvr.
// The slave modport is the transceiver's view; master is the pin driver and core view.
interface spi_slave_xcvr_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  SCK;
    logic                  SS;
    logic                  MOSI;
    logic                  CPOL;
    logic                  CPHA;
    logic                  MISO;
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  overrun;
    logic                  abort;
    logic                  busy;

    modport slave (
        input  SCK, SS, MOSI, CPOL, CPHA, tx_data, tx_valid, rx_ready,
        output MISO, tx_ready, rx_data, rx_valid, overrun, abort, busy
    );

    modport master (
        output SCK, SS, MOSI, CPOL, CPHA, tx_data, tx_valid, rx_ready,
        input  MISO, tx_ready, rx_data, rx_valid, overrun, abort, busy
    );
endinterface

// File: rtl/spi_slave_xcvr.sv
// Full-duplex SPI slave, oversampled in the clk domain, all four CPOL/CPHA modes.
// Define SPI_RX_FIFO_EN to replace the receive holding register with a FWFT FIFO.
module spi_slave_xcvr #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic             clk,
    input logic             reset,
    spi_slave_xcvr_if.slave bus
);
    localparam int unsigned CntW = $clog2(DATA_WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(DATA_WIDTH - 1);

    if (DATA_WIDTH < 2) begin : g_bad_width
        $error("DATA_WIDTH must be at least 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of 2, at least 2");
    end

    typedef enum logic [0:0] {StIdle, StShift} state_e;

    state_e                state_q, state_d;
    logic [1:0]            sck_sync_q, ss_sync_q, mosi_sync_q;
    logic                  sck_prev_q, ss_prev_q;
    logic [CntW-1:0]       bit_cnt_q;
    logic [DATA_WIDTH-1:0] tx_sr_q, rx_sr_q, tx_buf_q;
    logic                  tx_full_q, miso_q, abort_q, push_q, overrun_q;

    logic sck_s, mosi_s, sck_edge, leading, trailing, sample_edge, shift_edge;
    logic ss_fall, ss_rise;
    logic load, sample, shift, go_idle, word_done, tx_write;
    logic [DATA_WIDTH-1:0] tx_word, rx_next;

    function automatic logic head(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? w[DATA_WIDTH-1] : w[0];
    endfunction

    function automatic logic [DATA_WIDTH-1:0] advance(input logic [DATA_WIDTH-1:0] w);
        return MSB_FIRST ? {w[DATA_WIDTH-2:0], 1'b0} : {1'b0, w[DATA_WIDTH-1:1]};
    endfunction

    // SS synchronisers reset low so a frame already in progress at reset release is ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sck_sync_q  <= '0;
            ss_sync_q   <= '0;
            mosi_sync_q <= '0;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b0;
        end else begin
            sck_sync_q  <= {sck_sync_q[0], bus.SCK};
            ss_sync_q   <= {ss_sync_q[0], bus.SS};
            mosi_sync_q <= {mosi_sync_q[0], bus.MOSI};
            sck_prev_q  <= sck_sync_q[1];
            ss_prev_q   <= ss_sync_q[1];
        end
    end

    always_comb begin
        sck_s       = sck_sync_q[1];
        mosi_s      = mosi_sync_q[1];
        sck_edge    = sck_s ^ sck_prev_q;
        leading     = sck_edge && (sck_s != bus.CPOL);
        trailing    = sck_edge && (sck_s == bus.CPOL);
        sample_edge = bus.CPHA ? trailing : leading;
        shift_edge  = bus.CPHA ? leading : trailing;
        ss_fall     = ss_prev_q && !ss_sync_q[1];
        ss_rise     = !ss_prev_q && ss_sync_q[1];
        tx_word     = tx_full_q ? tx_buf_q : '0;
        tx_write    = bus.tx_valid && !tx_full_q;
        rx_next     = MSB_FIRST ? {rx_sr_q[DATA_WIDTH-2:0], mosi_s}
                                : {mosi_s, rx_sr_q[DATA_WIDTH-1:1]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        load      = 1'b0;
        sample    = 1'b0;
        shift     = 1'b0;
        go_idle   = 1'b0;
        word_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (ss_fall) begin
                    state_d = StShift;
                    load    = 1'b1;
                end
            end
            StShift: begin
                if (ss_rise) begin
                    state_d = StIdle;
                    go_idle = 1'b1;
                end else begin
                    if (sample_edge) begin
                        sample = 1'b1;
                        if (bit_cnt_q == LastBit) begin
                            word_done = 1'b1;
                            load      = 1'b1;
                        end
                    end
                    // CPHA=0 already presented the first bit at reload; skip the boundary edge.
                    if (shift_edge && (bus.CPHA || bit_cnt_q != '0)) begin
                        shift = 1'b1;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // A write coinciding with a reload lands in the buffer; the reload saw it empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_buf_q  <= '0;
            tx_full_q <= 1'b0;
        end else if (tx_write) begin
            tx_buf_q  <= bus.tx_data;
            tx_full_q <= 1'b1;
        end else if (load) begin
            tx_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bit_cnt_q <= '0;
            tx_sr_q   <= '0;
            rx_sr_q   <= '0;
            miso_q    <= 1'b0;
            abort_q   <= 1'b0;
            push_q    <= 1'b0;
        end else begin
            abort_q <= go_idle && (bit_cnt_q != '0);
            push_q  <= word_done;
            if (go_idle) begin
                miso_q    <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                if (load) begin
                    bit_cnt_q <= '0;
                end else if (sample) begin
                    bit_cnt_q <= bit_cnt_q + CntW'(1);
                end
                if (sample) begin
                    rx_sr_q <= rx_next;
                end
                if (load) begin
                    if (bus.CPHA) begin
                        tx_sr_q <= tx_word;
                    end else begin
                        tx_sr_q <= advance(tx_word);
                        miso_q  <= head(tx_word);
                    end
                end else if (shift) begin
                    tx_sr_q <= advance(tx_sr_q);
                    miso_q  <= head(tx_sr_q);
                end
            end
        end
    end

`ifdef SPI_RX_FIFO_EN
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]       wr_ptr_q, rd_ptr_q;
    logic [PtrW:0]         count_q;
    logic                  fifo_full, fifo_empty, rx_pop, rx_push;

    always_comb begin
        fifo_full  = (count_q == (PtrW + 1)'(FIFO_DEPTH));
        fifo_empty = (count_q == '0);
        rx_pop     = !fifo_empty && bus.rx_ready;
        rx_push    = push_q && (!fifo_full || rx_pop);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (rx_push) begin
                mem_q[wr_ptr_q] <= rx_sr_q;
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (push_q && !rx_push) begin
                overrun_q <= 1'b1;
            end
            if (rx_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (rx_push && !rx_pop) begin
                count_q <= count_q + (PtrW + 1)'(1);
            end else if (rx_pop && !rx_push) begin
                count_q <= count_q - (PtrW + 1)'(1);
            end
        end
    end

    assign bus.rx_data  = mem_q[rd_ptr_q];
    assign bus.rx_valid = !fifo_empty;
`else
    logic [DATA_WIDTH-1:0] rx_data_q;
    logic                  rx_valid_q, rx_pop;

    assign rx_pop = rx_valid_q && bus.rx_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else if (push_q) begin
            if (!rx_valid_q || rx_pop) begin
                rx_data_q  <= rx_sr_q;
                rx_valid_q <= 1'b1;
            end else begin
                overrun_q <= 1'b1;
            end
        end else if (rx_pop) begin
            rx_valid_q <= 1'b0;
        end
    end

    assign bus.rx_data  = rx_data_q;
    assign bus.rx_valid = rx_valid_q;
`endif

    assign bus.MISO     = miso_q;
    assign bus.tx_ready = !tx_full_q;
    assign bus.overrun  = overrun_q;
    assign bus.abort    = abort_q;
    assign bus.busy     = (state_q == StShift);

endmodule
